// File: rtl/mem_wr_queue.sv
// mem_wr_queue: sweeps INIT into every address, then drains a small
// valid/ready write queue into mem; lookup forwards newest queued data.
module mem_wr_queue #(
   parameter int unsigned      WIDTH  = 80,
   parameter int unsigned      DEPTH  = 64,
   parameter int unsigned      QDEPTH = 4,
   parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}},
   localparam int unsigned     AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_addr,
   input  logic [WIDTH-1:0] in_data,
   output logic             mem_wen,
   output logic [AW-1:0]    mem_waddr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             init_done,
   input  logic [AW-1:0]    lk_addr,
   output logic             lk_hit,
   output logic [WIDTH-1:0] lk_data
);

   localparam int unsigned QW = $clog2(QDEPTH);
   localparam int unsigned PW = QW + 1;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [AW-1:0]    r_cnt;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_q_addr [QDEPTH];
   logic [WIDTH-1:0] r_q_data [QDEPTH];
   logic [AW-1:0]    r_last_addr;
   logic [WIDTH-1:0] r_last_data;

   logic [PW-1:0]    w_count;
   logic [QW-1:0]    w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_wen;
   logic             w_sweep_end;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata;

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_head      = r_rd_ptr[QW-1:0];
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[QW] != r_rd_ptr[QW]) &&
                        (r_wr_ptr[QW-1:0] == r_rd_ptr[QW-1:0]);
   assign w_ready     = !w_full && !rst;
   assign w_push      = in_valid && w_ready;
   assign w_sweep_end = (r_state == S_INIT) &&
                        (r_cnt == AW'(DEPTH - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // next state: RUN is terminal until reset
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_INIT: begin
            if (w_sweep_end) begin
               w_state_nx = S_RUN;
            end
         end
         S_RUN: begin
            w_state_nx = S_RUN;
         end
      endcase
   end

   // outputs: sweep in INIT, queue head in RUN
   always_comb begin
      w_wen   = 1'b0;
      w_pop   = 1'b0;
      w_waddr = r_last_addr;
      w_wdata = r_last_data;
      unique case (r_state)
         S_INIT: begin
            w_wen   = 1'b1;
            w_waddr = r_cnt;
            w_wdata = INIT;
         end
         S_RUN: begin
            if (!w_empty) begin
               w_wen   = 1'b1;
               w_pop   = 1'b1;
               w_waddr = r_q_addr[w_head];
               w_wdata = r_q_data[w_head];
            end
         end
      endcase
      if (rst) begin
         w_wen = 1'b0;
         w_pop = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == S_INIT) begin
         r_cnt <= r_cnt + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr[QW-1:0]] <= in_addr;
         r_q_data[r_wr_ptr[QW-1:0]] <= in_data;
      end
   end

   // bus holds the last written beat while the queue is idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_addr <= '0;
         r_last_data <= INIT;
      end else if (w_wen) begin
         r_last_addr <= w_waddr;
         r_last_data <= w_wdata;
      end
   end

   // oldest to youngest; a later match overrides an earlier one
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
         logic [QW-1:0] v_slot;
         v_slot = w_head + QW'(i);
         if ((PW'(i) < w_count) && (r_q_addr[v_slot] == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = r_q_data[v_slot];
         end
      end
   end

   assign in_ready  = w_ready;
   assign mem_wen   = w_wen;
   assign mem_waddr = w_waddr;
   assign mem_wdata = w_wdata;
   assign init_done = (r_state == S_RUN);

endmodule

// File: tb/tb_mem_wr_queue.sv
// tb_mem_wr_queue: random and directed traffic against a queue-based
// reference model of the init sweep, write ordering and lookup.
module tb_mem_wr_queue;

   localparam int W  = 80;
   localparam int D  = 64;
   localparam int QD = 4;
   localparam int AW = $clog2(D);
   localparam logic [W-1:0] INITV = 80'hC3C3_5A5A_0F0F_F0F0_1234;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [W-1:0]  d;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [W-1:0]  in_data;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [W-1:0]  mem_wdata;
   logic          init_done;
   logic [AW-1:0] lk_addr;
   logic          lk_hit;
   logic [W-1:0]  lk_data;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_sweep = 0;
   ent_t mq[$];
   bit   m_init;
   int   m_cnt;

   mem_wr_queue #(
      .WIDTH (W),
      .DEPTH (D),
      .QDEPTH(QD),
      .INIT  (INITV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .mem_wen  (mem_wen),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .init_done(init_done),
      .lk_addr  (lk_addr),
      .lk_hit   (lk_hit),
      .lk_data  (lk_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      return W'({$urandom(), $urandom(), $urandom()});
   endfunction

   // called at a negedge; returns at the following negedge
   task automatic step(input bit v, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [AW-1:0] la);
      bit            e_rdy;
      bit            e_wen;
      bit            e_hit;
      logic [AW-1:0] e_wa;
      logic [W-1:0]  e_wd;
      logic [W-1:0]  e_ld;
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      lk_addr  = la;
      #1;
      e_rdy = (mq.size() < QD);
      e_wen = m_init || (mq.size() > 0);
      e_wa  = '0;
      e_wd  = '0;
      if (m_init) begin
         e_wa = AW'(m_cnt);
         e_wd = INITV;
      end else if (e_wen) begin
         e_wa = mq[0].a;
         e_wd = mq[0].d;
      end
      e_hit = 1'b0;
      e_ld  = '0;
      foreach (mq[i]) begin
         if (mq[i].a == la) begin
            e_hit = 1'b1;
            e_ld  = mq[i].d;
         end
      end
      if (m_init && mem_wen) n_sweep++;
      chk("in_ready", in_ready, e_rdy);
      chk("mem_wen", mem_wen, e_wen);
      if (e_wen) begin
         chk("mem_waddr", mem_waddr, e_wa);
         chk("mem_wdata", mem_wdata, e_wd);
      end
      chk("init_done", init_done, !m_init);
      chk("lk_hit", lk_hit, e_hit);
      chk("lk_data", lk_data, e_ld);
      @(posedge clk);
      if (e_wen) begin
         if (m_init) begin
            m_cnt++;
            if (m_cnt == D) m_init = 1'b0;
         end else begin
            void'(mq.pop_front());
         end
      end
      if (v && e_rdy) mq.push_back('{a: a, d: d});
      @(negedge clk);
   endtask

   // asserts reset right away (caller is at a negedge)
   task automatic do_reset(input logic [AW-1:0] la);
      rst      = 1'b1;
      in_valid = 1'b1;
      lk_addr  = la;
      #1;
      chk("rst_wen", mem_wen, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_done", init_done, 1'b0);
      chk("rst_hit", lk_hit, 1'b0);
      chk("rst_ldata", lk_data, '0);
      chk("rst_waddr", mem_waddr, '0);
      chk("rst_wdata", mem_wdata, INITV);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      mq.delete();
      m_init  = 1'b1;
      m_cnt   = 0;
      n_sweep = 0;
   endtask

   task automatic rand_steps(input int n, input int pct);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(0, 99) < pct, AW'($urandom_range(0, 7)),
              rnd_data(), AW'($urandom_range(0, 7)));
      end
   endtask

   initial begin
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      lk_addr  = '0;
      do_reset('0);

      // buffering during the sweep, queue fills, lookup priority
      step(0, 0, '0, 3);
      step(1, 5, W'('hA), 3);
      step(1, 9, W'('hB), 3);
      step(1, 3, W'('h11), 3);
      step(1, 3, W'('h22), 3);
      step(1, 7, W'('h33), 7);
      for (int i = 0; i < 58; i++) step(0, 0, '0, (i % 2) ? 7 : 3);
      chk("sweep_len", n_sweep, D);

      // drain: 5, 9, 3/11, 3/22; then lookups miss
      for (int i = 0; i < 6; i++) step(0, 0, '0, (i % 2) ? 7 : 3);

      // back-to-back pushes with simultaneous pops
      for (int i = 0; i < 8; i++) step(1, AW'(i), rnd_data(), AW'(i));
      step(0, 0, '0, 7);
      step(0, 0, '0, 3);

      // reset with three entries queued mid-sweep
      do_reset('0);
      step(1, 1, rnd_data(), 2);
      step(1, 2, rnd_data(), 2);
      step(1, 4, rnd_data(), 2);
      do_reset(2);
      rand_steps(70, 30);

      for (int b = 0; b < 8; b++) rand_steps(50, (b % 3) * 45 + 10);

      // reset during random run traffic
      do_reset(AW'($urandom_range(0, 7)));
      rand_steps(120, 70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
